segment_display_sched: RTL and testbench

//  Time-shares the two-digit segment LED display between N requesters.
//  - Each requester offers an 8-bit value with a valid/ready handshake.
//  - A round-robin arbiter grants one requester. Its value is latched and shown for HOLD_CYCLES clocks.
//  - Sits between the system sources and the segment decoder. count_out feeds the decoder's count input.

---
 rtl/segment_display_sched.sv | 161 ++++++++++++++++
 tb/tb_segment_display_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/segment_display_sched.sv
// Round-robin time-sharing of the two-digit segment display among N_REQ requesters.
// Optional blink support is enabled with the macro SEGMENT_DISPLAY_SCHED_BLINK_EN.
module segment_display_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned BLINK_DIV   = 12500000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
  input  logic [N_REQ-1:0]   blink_req,
`endif
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         count_out,
  output logic               disp_en,
  output logic [2:0]         grant_id,
  output logic               busy
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned ID_W   = 3;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
  localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV + 1) : 1;
`endif

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        count_q, count_d;
  logic [ID_W-1:0]   gid_q, gid_d;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
  logic              blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              sel_blink_c;
`endif

  logic              found_c;
  logic [ID_W-1:0]   sel_c;
  logic [7:0]        sel_data_c;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    found_c    = 1'b0;
    sel_c      = '0;
    sel_data_c = '0;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
    sel_blink_c = 1'b0;
`endif
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found_c && cand == i && req_valid[i]) begin
          found_c = 1'b1;
          sel_c   = ID_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_c == ID_W'(i)) begin
        sel_data_c = req_data[8*i +: 8];
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
        sel_blink_c = blink_req[i];
`endif
      end
    end
  end

  // Accept pulse; masked while reset is asserted so nothing is handed over.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = rst_n_in && (state_q == IDLE) && found_c && (sel_c == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    gid_d   = gid_q;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
    blink_d = blink_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = SHOW;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
          ptr_d   = sel_c;
          count_d = sel_data_c;
          gid_d   = sel_c;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
          blink_d = sel_blink_c;
          phase_d = 1'b1;
          bcnt_d  = '0;
`endif
        end
      end
      SHOW: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
        // Phase flips after every BLINK_DIV shown clocks.
        if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d  = bcnt_q + BCNT_W'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      count_q <= '0;
      gid_q   <= '0;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
      blink_q <= 1'b0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      gid_q   <= gid_d;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
      blink_q <= blink_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign count_out = count_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q == SHOW);
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
  assign disp_en   = (state_q == SHOW) && (!blink_q || phase_q);
`else
  assign disp_en   = (state_q == SHOW);
`endif

endmodule

// File: tb/tb_segment_display_sched.sv
// Bench for segment_display_sched: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the display scheduler.
module tb_segment_display_sched;
  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int BDIV = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid;
  logic [8*N-1:0] data;
  logic [N-1:0]  blink;
  logic [N-1:0]  ready;
  logic [7:0]    count_out;
  logic          disp_en;
  logic [2:0]    grant_id;
  logic          busy;

  segment_display_sched #(.N_REQ(N), .HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid(valid), .req_data(data),
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
    .blink_req(blink),
`endif
    .req_ready(ready), .count_out(count_out), .disp_en(disp_en),
    .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: which requester is next in rotation after ptr.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  bit       m_show;
  int       m_left, m_ptr, m_count, m_gid, m_elapsed;
  bit       m_blink;
  int       m_sel, m_disp, r2cnt;
  logic [N-1:0] m_rdy, ready_seen;
  int       grants_q[$];

  // Every cycle: compare DUT with the model, then advance the model by one clock.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_show = 0; m_left = 0; m_ptr = N - 1; m_count = 0; m_gid = 0;
      m_elapsed = 0; m_blink = 0; ready_seen = '0;
      chk("rst_ready", int'(ready), 0);
      chk("rst_count", int'(count_out), 0);
      chk("rst_disp", int'(disp_en), 0);
      chk("rst_gid", int'(grant_id), 0);
      chk("rst_busy", int'(busy), 0);
    end else begin
      m_sel  = m_show ? -1 : pick(valid, m_ptr);
      m_rdy  = (m_sel >= 0) ? N'(1 << m_sel) : '0;
      m_disp = (m_show && (!m_blink || ((m_elapsed / BDIV) % 2 == 0))) ? 1 : 0;
      chk("ready", int'(ready), int'(m_rdy));
      chk("count_out", int'(count_out), m_count);
      chk("disp_en", int'(disp_en), m_disp);
      chk("grant_id", int'(grant_id), m_gid);
      chk("busy", int'(busy), m_show ? 1 : 0);
      ready_seen = ready;
      if (ready[2]) r2cnt++;
      for (int i = 0; i < N; i++) if (ready[i]) grants_q.push_back(i);
      if (m_show) begin
        m_elapsed++;
        m_left--;
        if (m_left == 0) m_show = 0;
      end else if (m_sel >= 0) begin
        m_show = 1; m_left = HOLD; m_elapsed = 0;
        m_count = int'(data[8*m_sel +: 8]); m_gid = m_sel; m_ptr = m_sel;
`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
        m_blink = blink[m_sel];
`else
        m_blink = 0;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drop_granted();
    valid = valid & ~ready_seen;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; blink = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  int dcnt;
  logic [7:0] pat;

  initial begin
    rst_n = 1'b0; valid = '0; data = '0; blink = '0; r2cnt = 0;
    do_reset();

    // 1: single request, value 42 shown for exactly HOLD clocks
    data[7:0] = 8'd42; valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", int'(ready), 1);
    tick(); drop_granted();
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (disp_en) dcnt++; end
    chk("t1_disp_cycles", dcnt, 8);
    chk("t1_count", int'(count_out), 42);
    tick();

    // 2: all four held -> rotation 0,1,2,3,0
    do_reset();
    data = {8'd40, 8'd30, 8'd20, 8'd10}; valid = 4'b1111;
    grants_q.delete();
    repeat (45) tick();
    chk("t2_ngrants", grants_q.size(), 5);
    if (grants_q.size() == 5) begin
      chk("t2_g0", grants_q[0], 0); chk("t2_g1", grants_q[1], 1);
      chk("t2_g2", grants_q[2], 2); chk("t2_g3", grants_q[3], 3);
      chk("t2_g4", grants_q[4], 0);
    end

    // 3: after grant 2 only 1 and 3 remain -> 3 then 1
    do_reset();
    valid = 4'b1111; grants_q.delete();
    for (int c = 0; c < 100 && grants_q.size() < 3; c++) tick();
    chk("t3_reach3", grants_q.size(), 3);
    valid = 4'b1010;
    for (int c = 0; c < 100 && grants_q.size() < 5; c++) tick();
    chk("t3_reach5", grants_q.size(), 5);
    if (grants_q.size() >= 5) begin
      chk("t3_g3", grants_q[3], 3); chk("t3_g4", grants_q[4], 1);
    end

    // 4: requester 2 pulses during SHOW and withdraws -> never granted
    do_reset();
    data[7:0] = 8'd77; valid = 4'b0001; r2cnt = 0;
    tick(); drop_granted();
    repeat (2) tick();
    data[23:16] = 8'd99; valid[2] = 1'b1;
    repeat (3) tick();
    valid[2] = 1'b0;
    repeat (12) tick();
    chk("t4_ready2", r2cnt, 0);
    chk("t4_count", int'(count_out), 77);

    // 5: async reset at hold=4, then lowest valid index wins
    do_reset();
    data[7:0] = 8'd5; data[15:8] = 8'd6; valid = 4'b0011;
    tick(); drop_granted();
    repeat (3) tick();
    chk("t5_busy_before", int'(busy), 1);
    rst_n = 1'b0; valid = 4'b0110;
    #1;
    chk("t5_async_disp", int'(disp_en), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_count", int'(count_out), 0);
    chk("t5_async_ready", int'(ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_grant", int'(ready), 2);
    tick(); drop_granted();
    repeat (10) tick();

`ifdef SEGMENT_DISPLAY_SCHED_BLINK_EN
    // 6: blinking grant, value 255
    do_reset();
    blink = 4'b0001; data[7:0] = 8'd255; valid = 4'b0001;
    tick(); drop_granted();
    pat = '0;
    repeat (8) begin @(negedge clk); pat = {pat[6:0], disp_en}; end
    chk("t6_blink_pat", int'(pat), 8'b11001100);
    chk("t6_count", int'(count_out), 255);
    tick(); repeat (3) tick();
`endif

    // Randomized traffic with withdrawals, re-requests and one mid-run reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c == 2000) begin
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (valid[i] && ready_seen[i]) valid[i] = 1'b0;
        if (!valid[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            valid[i] = 1'b1;
            data[8*i +: 8] = 8'($urandom);
            blink[i] = 1'($urandom);
          end
        end else if ($urandom_range(0, 40) == 0) begin
          valid[i] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
